axi4_lite_usr_responder: RTL and testbench
==========================================

// Module: axi4_lite_usr_responder
// PURPOSE
//  AXI4-Lite slave endpoint: the responder for transactions issued on an AXI4-Lite master's user port.
//  Holds NUM_REGS registers of DATA_WIDTH bits with byte-strobe writes.
//  Register 0 is a read-only ID. Out-of-range accesses return DECERR.
//  Used as the DUT-side target in bridge loopback benches and as a small control/status block.
// PARAMETERS
//  ADDR_WIDTH   64            s_axi_awaddr/araddr width (32 or 64)
//  DATA_WIDTH   32            data width (32 or 64); BYTES=DATA_WIDTH/8, LSB=log2(BYTES)
//  NUM_REGS     16            register count, power of two, 2..256; IDX_W=log2(NUM_REGS)
//  ID_VALUE     32'hA1A1_0001 constant returned by register 0, zero-extended to DATA_WIDTH
//  RESET_VALUE  0             reset value of registers 1..NUM_REGS-1
//  RD_LATENCY   0             extra wait cycles between AR handshake and rvalid (0..15)
// PORTS
//  axi_aclk       in   1           clock
//  axi_aresetn    in   1           asynchronous active-low reset
//  s_axi_awaddr   in   ADDR_WIDTH  write address
//  s_axi_awprot   in   3           ignored
//  s_axi_awvalid  in   1           AW valid
//  s_axi_awready  out  1           AW ready
//  s_axi_wdata    in   DATA_WIDTH  write data
//  s_axi_wstrb    in   BYTES       byte enables
//  s_axi_wvalid   in   1           W valid
//  s_axi_wready   out  1           W ready
//  s_axi_bresp    out  2           00 OKAY, 10 SLVERR, 11 DECERR
//  s_axi_bvalid   out  1           B valid
//  s_axi_bready   in   1           B ready
//  s_axi_araddr   in   ADDR_WIDTH  read address
//  s_axi_arprot   in   3           ignored
//  s_axi_arvalid  in   1           AR valid
//  s_axi_arready  out  1           AR ready
//  s_axi_rdata    out  DATA_WIDTH  read data
//  s_axi_rresp    out  2           read response
//  s_axi_rvalid   out  1           R valid
//  s_axi_rready   in   1           R ready
//  reg_wr_pulse   out  1           1-cycle pulse on each committed (OKAY) register write
//  reg_wr_index   out  IDX_W       index of last committed write; valid with reg_wr_pulse
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; registers 1..N-1 = RESET_VALUE; both FSMs idle.
//   Ready flops rise on the first clock edge after release.
//  Reset mid-transaction: abort immediately, drop bvalid/rvalid; no partial register write survives.
//  Decode: idx=addr[LSB+:IDX_W]; addr[LSB-1:0] ignored; addr >= NUM_REGS*BYTES -> out of range.
//  All ready/valid outputs are registered; no combinational path from any input to any output.
//  Write FSM: W_IDLE -> W_HAVE_A | W_HAVE_D | W_COMMIT -> W_RESP -> W_IDLE.
//   AW and W are accepted in either order or in the same cycle.
//   awready=1 only while no address is held; wready=1 only while no data is held.
//   Both are 0 in W_COMMIT and W_RESP.
//   W_COMMIT (1 cycle after both are held): perform the write, then raise bvalid at the next edge.
//   Write response:
//    - in range, idx!=0: write each byte whose wstrb bit is 1; bresp=OKAY; reg_wr_pulse=1.
//    - idx==0: no write; bresp=SLVERR. Out of range: no write; bresp=DECERR.
//    - wstrb==0 in range: no register change; OKAY; pulse still fires.
//   W_RESP: bvalid and bresp held until bready. Ready outputs re-assert on the edge after the B handshake.
//   Minimum write issue interval: 4 cycles.
//  Read FSM: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
//   arready=1 only in R_IDLE. On AR handshake, latch address and load cnt=RD_LATENCY.
//   R_WAIT decrements cnt. At cnt==0, capture data and set rvalid at the next edge.
//   rvalid rises RD_LATENCY+2 edges after the AR handshake edge.
//   rdata: idx0 -> ID_VALUE; in range -> register; out of range -> 0 with rresp=DECERR; else OKAY.
//   rdata/rresp stable while rvalid && !rready; arready re-asserts on the edge after the R handshake.
//  Read and write channels are fully independent and may be active at the same time.
//   Read capture and write commit to the same idx in the same cycle: read returns the pre-write value.
// TESTING
//  Reset, then AW+W same cycle: 0x8, 0xDEADBEEF, wstrb F -> bresp 00, pulse idx 2; read 0x8 -> 0xDEADBEEF.
//  W 0x11223344 issued 3 cycles before AW 0xC, wstrb 0101 -> reg3 = 0x00220044 (RESET_VALUE 0).
//  Write 0x0 -> bresp 10, no pulse; read 0x0 -> ID_VALUE, rresp 00.
//  Read 0x40 with NUM_REGS=16 -> rdata 0, rresp 11; write 0x40 -> bresp 11, no register changed.
//  RD_LATENCY=3, rready held low 5 cycles -> rvalid 5 edges after AR; rdata/rresp stable until accepted.
//  Reset asserted while bvalid=1 -> bvalid falls at once; after release all regs = RESET_VALUE, FSMs idle.

Source files
------------

// File: rtl/axi4_lite_usr_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_usr_responder
// Brief    : AXI4-Lite slave with a small byte-strobed register file and a
//            read-only ID register at index 0.
// Revision : 1.0
// ============================================================================
module axi4_lite_usr_responder #(
    parameter int unsigned            ADDR_WIDTH  = 64,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            NUM_REGS    = 16,
    parameter logic [31:0]            ID_VALUE    = 32'hA1A1_0001,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned            RD_LATENCY  = 0,
    localparam int unsigned           BYTES       = DATA_WIDTH / 8,
    localparam int unsigned           IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [BYTES-1:0]      s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  reg_wr_pulse,
    output logic [IDX_W-1:0]      reg_wr_index
);

    localparam int unsigned           LSB      = $clog2(BYTES);
    localparam logic [DATA_WIDTH-1:0] ID_EXT   = DATA_WIDTH'(ID_VALUE);
    localparam logic [3:0]            CNT_INIT = 4'(RD_LATENCY);
    localparam logic [1:0]            C_OKAY   = 2'b00;
    localparam logic [1:0]            C_SLVERR = 2'b10;
    localparam logic [1:0]            C_DECERR = 2'b11;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_HAVE_A = 3'd1,
        W_HAVE_D = 3'd2,
        W_COMMIT = 3'd3,
        W_RESP   = 3'd4
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rstate_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (LSB + IDX_W)) == '0;
    endfunction

    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t                wst_q, wst_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [IDX_W-1:0]       widx_q, widx_d;
    logic                   wrange_q, wrange_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BYTES-1:0]       wstrb_q, wstrb_d;
    logic                   pulse_q, pulse_d;
    logic [IDX_W-1:0]       pidx_q, pidx_d;
    logic                   w_aw_hs, w_w_hs, w_commit, w_wr_en;

    assign w_aw_hs = s_axi_awvalid && awready_q;
    assign w_w_hs  = s_axi_wvalid && wready_q;

    always_comb begin
        wst_d    = wst_q;
        widx_d   = widx_q;
        wrange_d = wrange_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        pulse_d  = 1'b0;
        pidx_d   = pidx_q;
        w_commit = 1'b0;

        if (w_aw_hs) begin
            widx_d   = s_axi_awaddr[LSB +: IDX_W];
            wrange_d = in_range(s_axi_awaddr);
        end
        if (w_w_hs) begin
            wdata_d = s_axi_wdata;
            wstrb_d = s_axi_wstrb;
        end

        case (wst_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) wst_d = W_COMMIT;
                else if (w_aw_hs)      wst_d = W_HAVE_A;
                else if (w_w_hs)       wst_d = W_HAVE_D;
            end
            W_HAVE_A: if (w_w_hs)  wst_d = W_COMMIT;
            W_HAVE_D: if (w_aw_hs) wst_d = W_COMMIT;
            W_COMMIT: begin
                w_commit = 1'b1;
                wst_d    = W_RESP;
                bvalid_d = 1'b1;
                if (!wrange_q) begin
                    bresp_d = C_DECERR;
                end else if (widx_q == '0) begin
                    bresp_d = C_SLVERR;
                end else begin
                    bresp_d = C_OKAY;
                    pulse_d = 1'b1;
                    pidx_d  = widx_q;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wst_d    = W_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: wst_d = W_IDLE;
        endcase

        // Readies stay low for the cycle following the B handshake.
        awready_d = (wst_d == W_IDLE && wst_q == W_IDLE) || (wst_d == W_HAVE_D);
        wready_d  = (wst_d == W_IDLE && wst_q == W_IDLE) || (wst_d == W_HAVE_A);
    end

    assign w_wr_en = w_commit && wrange_q && (widx_q != '0);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wst_q     <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            widx_q    <= '0;
            wrange_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            pulse_q   <= 1'b0;
            pidx_q    <= '0;
        end else begin
            wst_q     <= wst_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            widx_q    <= widx_d;
            wrange_q  <= wrange_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            pulse_q   <= pulse_d;
            pidx_q    <= pidx_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file (index 0 is the constant ID)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_vals [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        if (i == 0) begin : g_id
            assign rd_vals[i] = ID_EXT;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] reg_q;
            always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
                if (!axi_aresetn) begin
                    reg_q <= RESET_VALUE;
                end else if (w_wr_en && (widx_q == IDX_W'(i))) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (wstrb_q[b]) reg_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
            assign rd_vals[i] = reg_q;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t                rst_q, rst_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [IDX_W-1:0]       ridx_q, ridx_d;
    logic                   rrange_q, rrange_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   w_ar_hs;

    assign w_ar_hs = s_axi_arvalid && arready_q;

    always_comb begin
        rst_d    = rst_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        ridx_d   = ridx_q;
        rrange_d = rrange_q;
        cnt_d    = cnt_q;

        case (rst_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    ridx_d   = s_axi_araddr[LSB +: IDX_W];
                    rrange_d = in_range(s_axi_araddr);
                    cnt_d    = CNT_INIT;
                    rst_d    = R_WAIT;
                end
            end
            R_WAIT: begin
                // Capture samples the registers before any same-edge commit.
                if (cnt_q == 4'd0) begin
                    rdata_d = rrange_q ? rd_vals[ridx_q] : '0;
                    rresp_d = rrange_q ? C_OKAY : C_DECERR;
                    rst_d   = R_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                end else if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rst_d    = R_IDLE;
                end
            end
            default: rst_d = R_IDLE;
        endcase

        arready_d = (rst_d == R_IDLE) && (rst_q == R_IDLE);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rst_q     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            ridx_q    <= '0;
            rrange_q  <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            rst_q     <= rst_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ridx_q    <= ridx_d;
            rrange_q  <= rrange_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign reg_wr_pulse  = pulse_q;
    assign reg_wr_index  = pidx_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_usr_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_usr_responder
// Brief    : Directed scoreboard bench for axi4_lite_usr_responder.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_usr_responder;

    localparam int unsigned RDL = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [63:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        wr_pulse;
    logic [3:0]  wr_index;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [1:0] resp;
        logic       pulse;
        logic [3:0] idx;
    } bexp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [31:0] mdl [16];

    always #5 clk = ~clk;

    axi4_lite_usr_responder #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .ID_VALUE   (32'hA1A1_0001),
        .RESET_VALUE(32'h0),
        .RD_LATENCY (RDL)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .s_axi_awaddr (awaddr),
        .s_axi_awprot (awprot),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arprot (arprot),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .reg_wr_pulse (wr_pulse),
        .reg_wr_index (wr_index)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic send_aw(input logic [63:0] a);
        int n = 0;
        awaddr  = a;
        awvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!wready && n < 50) begin @(negedge clk); n++; end
        if (!wready) chk("w_timeout", 64'(wready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a);
        int n = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) chk("ar_timeout", 64'(arready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic collect_b(input string tag);
        bexp_t e;
        int    n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        e = bq.pop_front();
        if (!bvalid) begin
            chk({tag, "_b_timeout"}, 64'(bvalid), 64'd1);
            return;
        end
        chk({tag, "_bresp"}, 64'(bresp), 64'(e.resp));
        chk({tag, "_pulse"}, 64'(wr_pulse), 64'(e.pulse));
        if (e.pulse) chk({tag, "_index"}, 64'(wr_index), 64'(e.idx));
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic collect_r(input string tag);
        rexp_t e;
        int    n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        e = rq.pop_front();
        if (!rvalid) begin
            chk({tag, "_r_timeout"}, 64'(rvalid), 64'd1);
            return;
        end
        chk({tag, "_rdata"}, 64'(rdata), 64'(e.data));
        chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    function automatic bexp_t model_write(input logic [63:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
        bexp_t      e;
        logic [3:0] i;
        i       = a[5:2];
        e.pulse = 1'b0;
        e.idx   = i;
        if (a >= 64'd64) begin
            e.resp = 2'b11;
        end else if (i == 4'd0) begin
            e.resp = 2'b10;
        end else begin
            e.resp  = 2'b00;
            e.pulse = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) mdl[i][b*8 +: 8] = d[b*8 +: 8];
        end
        return e;
    endfunction

    function automatic rexp_t model_read(input logic [63:0] a);
        rexp_t e;
        if (a >= 64'd64) begin
            e.data = 32'h0;
            e.resp = 2'b11;
        end else begin
            e.data = (a[5:2] == 4'd0) ? 32'hA1A1_0001 : mdl[a[5:2]];
            e.resp = 2'b00;
        end
        return e;
    endfunction

    task automatic write_txn(input string tag, input logic [63:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead);
        bq.push_back(model_write(a, d, s));
        if (lead == 0) begin
            fork
                send_aw(a);
                send_w(d, s);
            join
        end else begin
            send_w(d, s);
            repeat (lead - 1) @(negedge clk);
            send_aw(a);
        end
        collect_b(tag);
    endtask

    task automatic read_txn(input string tag, input logic [63:0] a);
        rq.push_back(model_read(a));
        send_ar(a);
        collect_r(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rexp_t re;
        int    n;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", 64'(awready), 64'd1);
        chk("rel_wready",  64'(wready),  64'd1);
        chk("rel_arready", 64'(arready), 64'd1);

        write_txn("wr_same_cycle", 64'h8, 32'hDEAD_BEEF, 4'hF, 0);
        read_txn("rd_reg2", 64'h8);

        write_txn("wr_w_first", 64'hC, 32'h1122_3344, 4'b0101, 3);
        read_txn("rd_reg3", 64'hC);

        write_txn("wr_id", 64'h0, 32'hFFFF_FFFF, 4'hF, 0);
        read_txn("rd_id", 64'h0);

        read_txn("rd_oor", 64'h40);
        write_txn("wr_oor", 64'h40, 32'h5555_5555, 4'hF, 0);
        read_txn("rd_reg2_after_oor", 64'h8);
        read_txn("rd_reg3_after_oor", 64'hC);

        write_txn("wr_strb0", 64'h14, 32'h1234_5678, 4'h0, 0);
        read_txn("rd_reg5_strb0", 64'h14);
        write_txn("wr_lowbits", 64'h17, 32'hAABB_CCDD, 4'b1100, 2);
        read_txn("rd_reg5_hi", 64'h14);

        // Read latency and hold-while-stalled
        rq.push_back(model_read(64'h8));
        araddr  = 64'h8;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 30) begin @(negedge clk); n++; end
        chk("rd_latency_edges", 64'(n), 64'(RDL + 2));
        re = rq.pop_front();
        for (int c = 0; c < 5; c++) begin
            chk("stall_rvalid", 64'(rvalid), 64'd1);
            chk("stall_rdata",  64'(rdata),  64'(re.data));
            chk("stall_rresp",  64'(rresp),  64'(re.resp));
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_after_accept", 64'(rvalid), 64'd0);

        // Reset while a write response is pending
        fork
            send_aw(64'h10);
            send_w(32'hCAFE_F00D, 4'hF);
        join
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk("pre_reset_bvalid", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_bvalid", 64'(bvalid),   64'd0);
        chk("async_pulse",  64'(wr_pulse), 64'd0);
        chk("async_awready", 64'(awready), 64'd0);
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 16; i++) read_txn("rd_after_reset", 64'(i * 4));
        read_txn("rd_id_after_reset", 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
